// File: rtl/vc_evict_ctrl.sv
// Victim-cache eviction sequencer: queues L1.5 evictions, writes back Modified VC victims, then store-evicts.
// Optional flush walk of all VC entries is compiled in when VC_FLUSH_EN is defined.
module vc_evict_ctrl #(
  parameter int ADDR_W      = 36,
  parameter int DATA_W      = 128,
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int QDEPTH      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              evq_val,
  output logic              evq_rdy,
  input  logic [ADDR_W-1:0] evq_addr,
  input  logic [DATA_W-1:0] evq_data,
  input  logic              pipe_val_s1,
  input  logic              pipe_rw_s1,
  input  logic [IDX_W-1:0]  vc_index_s2,
  input  logic [1:0]        vc_mesi_s2,
  input  logic [DATA_W-1:0] vc_data_s2,
  output logic              ctrl_vc_val_s1,
  output logic [ADDR_W-1:0] ctrl_vc_addr_s1,
  output logic              vc_se_val_s3,
  output logic [ADDR_W-1:0] vc_se_addr_s3,
  output logic [DATA_W-1:0] vc_se_data_s3,
  output logic              wb_val,
  input  logic              wb_rdy,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
`ifdef VC_FLUSH_EN
  ,
  input  logic              flush_req,
  output logic              flush_done
`endif
);

  localparam logic [1:0]       MESI_M   = 2'b11;
  localparam int               QPTR_W   = $clog2(QDEPTH);
  localparam int               CNT_W    = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] Q_FULL   = CNT_W'(QDEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_S1,
    S_RD_S2,
    S_WB
`ifdef VC_FLUSH_EN
    ,
    S_FLUSH
`endif
  } state_t;

  state_t              state_q, state_d, ret_state;
  logic [IDX_W-1:0]    ptr_q, idx;
  logic [NUM_ENTRIES-1:0] dirty_q;
  logic [ADDR_W-1:0]   shadow_addr_q [NUM_ENTRIES];
  logic                snoop_wr_q, snoop_hit, snoop_hit_idx;
  logic                redo_q, redo_d;
  logic [ADDR_W-1:0]   wb_addr_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                se_fire, rd_fire, capture, clr_dirty, push, flushing;

  logic [ADDR_W-1:0]   fifo_addr [QDEPTH];
  logic [DATA_W-1:0]   fifo_data [QDEPTH];
  logic [QPTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                fifo_empty, fifo_full;

  function automatic logic [QPTR_W-1:0] qnext(input logic [QPTR_W-1:0] p);
    return (p == QPTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef VC_FLUSH_EN
  logic             flushing_q, flush_pend_q, flush_done_q;
  logic [IDX_W-1:0] fidx_q;
  logic             flush_start, flush_end, fidx_inc;
  assign flushing  = flushing_q;
  assign idx       = flushing_q ? fidx_q : ptr_q;
  assign ret_state = flushing_q ? S_FLUSH : S_IDLE;
`else
  assign flushing  = 1'b0;
  assign idx       = ptr_q;
  assign ret_state = S_IDLE;
`endif

  assign fifo_empty    = (count_q == '0);
  assign fifo_full     = (count_q == Q_FULL);
  assign push          = evq_val && evq_rdy;
  // A pipe write seen last cycle resolves its MESI state in S2 this cycle.
  assign snoop_hit     = snoop_wr_q && (vc_mesi_s2 == MESI_M);
  assign snoop_hit_idx = snoop_hit && (vc_index_s2 == idx);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    redo_d    = redo_q;
    se_fire   = 1'b0;
    rd_fire   = 1'b0;
    capture   = 1'b0;
    clr_dirty = 1'b0;
`ifdef VC_FLUSH_EN
    flush_start = 1'b0;
    flush_end   = 1'b0;
    fidx_inc    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (dirty_q[ptr_q]) state_d = S_RD_S1;
          else                se_fire = 1'b1;
        end
`ifdef VC_FLUSH_EN
        else if (flush_pend_q) begin
          flush_start = 1'b1;
          state_d     = S_FLUSH;
        end
`endif
      end
      S_RD_S1: begin
        if (!pipe_val_s1) begin
          rd_fire = 1'b1;
          state_d = S_RD_S2;
        end
      end
      S_RD_S2: begin
        if (vc_mesi_s2 == MESI_M) begin
          capture = 1'b1;
          redo_d  = redo_q || snoop_hit_idx;
          state_d = S_WB;
        end else begin
          clr_dirty = 1'b1;
          redo_d    = 1'b0;
          state_d   = ret_state;
        end
      end
      S_WB: begin
        if (wb_rdy) begin
          redo_d = 1'b0;
          // A write that landed during the read/writeback makes our copy stale: read it again.
          if (redo_q || snoop_hit_idx) begin
            state_d = S_RD_S1;
          end else begin
            clr_dirty = 1'b1;
            state_d   = ret_state;
          end
        end else begin
          redo_d = redo_q || snoop_hit_idx;
        end
      end
`ifdef VC_FLUSH_EN
      S_FLUSH: begin
        if (dirty_q[fidx_q]) begin
          state_d = S_RD_S1;
        end else if (fidx_q == IDX_LAST) begin
          flush_end = 1'b1;
          state_d   = S_IDLE;
        end else begin
          fidx_inc = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      dirty_q    <= '0;
      snoop_wr_q <= 1'b0;
      redo_q     <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) shadow_addr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      redo_q     <= redo_d;
      snoop_wr_q <= pipe_val_s1 && pipe_rw_s1;
      count_q    <= count_q + CNT_W'(push) - CNT_W'(se_fire);
      if (push) wr_ptr_q <= qnext(wr_ptr_q);
      if (se_fire) begin
        rd_ptr_q              <= qnext(rd_ptr_q);
        shadow_addr_q[ptr_q]  <= fifo_addr[rd_ptr_q];
        ptr_q                 <= ptr_q + 1'b1;
        dirty_q[ptr_q]        <= 1'b0;
      end
      if (capture) begin
        wb_addr_q <= shadow_addr_q[idx];
        wb_data_q <= vc_data_s2;
      end
      if (clr_dirty) dirty_q[idx] <= 1'b0;
      // Ordered last: a fresh Modified write outranks any clear in the same cycle.
      if (snoop_hit) dirty_q[vc_index_s2] <= 1'b1;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= evq_addr;
      fifo_data[wr_ptr_q] <= evq_data;
    end
  end

`ifdef VC_FLUSH_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flushing_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      fidx_q       <= '0;
    end else begin
      flush_pend_q <= flush_req || (flush_pend_q && !flush_start);
      flush_done_q <= flush_end;
      if (flush_start) begin
        flushing_q <= 1'b1;
        fidx_q     <= '0;
      end
      if (flush_end) flushing_q <= 1'b0;
      if (fidx_inc)  fidx_q     <= fidx_q + 1'b1;
    end
  end
  assign flush_done = rst_n && flush_done_q;
`endif

  // Valid-type outputs are masked by rst_n so nothing fires while reset is held.
  assign evq_rdy         = rst_n && !fifo_full && !flushing;
  assign vc_se_val_s3    = rst_n && se_fire;
  assign vc_se_addr_s3   = se_fire ? fifo_addr[rd_ptr_q] : '0;
  assign vc_se_data_s3   = se_fire ? fifo_data[rd_ptr_q] : '0;
  assign ctrl_vc_val_s1  = rst_n && rd_fire;
  assign ctrl_vc_addr_s1 = rd_fire ? shadow_addr_q[idx] : '0;
  assign wb_val          = rst_n && (state_q == S_WB);
  assign wb_addr         = wb_addr_q;
  assign wb_data         = wb_data_q;
  assign busy            = rst_n && ((state_q != S_IDLE) || !fifo_empty);

endmodule

// File: tb/tb_vc_evict_ctrl.sv
// Scoreboard bench for vc_evict_ctrl: directed evictions queue expected VC read / writeback /
// store-evict events, a monitor pops and compares them in order. Flush case needs VC_FLUSH_EN.
module tb_vc_evict_ctrl;
  localparam int ADDR_W = 36, DATA_W = 128, NUM_ENTRIES = 16, IDX_W = 4;
  localparam logic [1:0] MESI_I = 2'b00, MESI_E = 2'b10, MESI_M = 2'b11;

  logic clk, rst_n;
  logic evq_val, evq_rdy;
  logic [ADDR_W-1:0] evq_addr;
  logic [DATA_W-1:0] evq_data;
  logic pipe_val_s1, pipe_rw_s1;
  logic [IDX_W-1:0] vc_index_s2;
  logic [1:0] vc_mesi_s2;
  logic [DATA_W-1:0] vc_data_s2;
  logic ctrl_vc_val_s1;
  logic [ADDR_W-1:0] ctrl_vc_addr_s1;
  logic vc_se_val_s3;
  logic [ADDR_W-1:0] vc_se_addr_s3;
  logic [DATA_W-1:0] vc_se_data_s3;
  logic wb_val, wb_rdy;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic busy;
`ifdef VC_FLUSH_EN
  logic flush_req, flush_done;
`endif

  vc_evict_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .evq_val(evq_val), .evq_rdy(evq_rdy), .evq_addr(evq_addr), .evq_data(evq_data),
    .pipe_val_s1(pipe_val_s1), .pipe_rw_s1(pipe_rw_s1),
    .vc_index_s2(vc_index_s2), .vc_mesi_s2(vc_mesi_s2), .vc_data_s2(vc_data_s2),
    .ctrl_vc_val_s1(ctrl_vc_val_s1), .ctrl_vc_addr_s1(ctrl_vc_addr_s1),
    .vc_se_val_s3(vc_se_val_s3), .vc_se_addr_s3(vc_se_addr_s3), .vc_se_data_s3(vc_se_data_s3),
    .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy)
`ifdef VC_FLUSH_EN
    , .flush_req(flush_req), .flush_done(flush_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_RD, EV_WB, EV_SE} ev_kind_t;
  typedef struct {
    ev_kind_t          kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Behavioural victim cache: fills round-robin on store-evict, answers S1 reads and pipe writes.
  logic [ADDR_W-1:0] vc_addr [NUM_ENTRIES];
  logic [1:0]        vc_mesi [NUM_ENTRIES];
  logic [DATA_W-1:0] vc_dat  [NUM_ENTRIES];
  int                mptr = 0;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  function automatic logic [ADDR_W-1:0] la(int i);
    return 36'hA_0000_0000 + ADDR_W'(i);
  endfunction
  function automatic logic [DATA_W-1:0] ld(int i);
    return {4{32'hD000_0000 + 32'(i)}};
  endfunction
  function automatic logic [DATA_W-1:0] vd(int i);
    return {4{32'h5EED_0000 + 32'(i)}};
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_take(input ev_kind_t k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_%s: got addr %h data %h, none expected", k.name(), a, d);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", DATA_W'(k), DATA_W'(e.kind));
      check("event_addr", DATA_W'(a), DATA_W'(e.addr));
      if (k != EV_RD) check("event_data", d, e.data);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_a;
    logic [DATA_W-1:0] prev_d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("wb_val_held", DATA_W'(wb_val), 1);
          check("wb_addr_held", DATA_W'(wb_addr), DATA_W'(prev_a));
          check("wb_data_held", wb_data, prev_d);
        end
        prev_stall = wb_val && !wb_rdy;
        prev_a = wb_addr;
        prev_d = wb_data;
        if (ctrl_vc_val_s1) begin
          check("rd_vs_pipe_overlap", DATA_W'(pipe_val_s1), 0);
          sb_take(EV_RD, ctrl_vc_addr_s1, '0);
        end
        if (wb_val && wb_rdy) sb_take(EV_WB, wb_addr, wb_data);
        if (vc_se_val_s3) begin
          sb_take(EV_SE, vc_se_addr_s3, vc_se_data_s3);
          vc_addr[mptr] = vc_se_addr_s3;
          vc_dat[mptr]  = vc_se_data_s3;
          vc_mesi[mptr] = MESI_E;
          mptr = (mptr + 1) % NUM_ENTRIES;
        end
      end
    end
  end

  // VC S2 responder: a cycle after an S1 access, present that entry's state/data.
  initial begin
    logic              rd_seen, wr_seen;
    logic [ADDR_W-1:0] rd_a;
    logic [IDX_W-1:0]  wi;
    logic [DATA_W-1:0] wd;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      vc_addr[i] = '0;
      vc_mesi[i] = MESI_I;
      vc_dat[i]  = '0;
    end
    vc_index_s2 = '0;
    vc_mesi_s2  = MESI_I;
    vc_data_s2  = '0;
    forever begin
      @(negedge clk);
      rd_seen = ctrl_vc_val_s1;
      rd_a    = ctrl_vc_addr_s1;
      wr_seen = pipe_val_s1 && pipe_rw_s1;
      wi      = wr_idx;
      wd      = wr_data;
      @(posedge clk);
      #1;
      vc_index_s2 = '0;
      vc_mesi_s2  = MESI_I;
      vc_data_s2  = '0;
      if (rd_seen) begin
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          if (vc_addr[j] == rd_a) begin
            vc_index_s2 = IDX_W'(j);
            vc_mesi_s2  = vc_mesi[j];
            vc_data_s2  = vc_dat[j];
          end
        end
      end else if (wr_seen) begin
        vc_index_s2 = wi;
        vc_mesi_s2  = MESI_M;
        vc_data_s2  = wd;
        vc_mesi[wi] = MESI_M;
        vc_dat[wi]  = wd;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back('{kind: k, addr: a, data: d});
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic push_ev(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    logic ok = 1'b0;
    evq_val  = 1'b1;
    evq_addr = a;
    evq_data = d;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (evq_rdy) ok = 1'b1;
      tick();
      n++;
    end
    evq_val = 1'b0;
    check("evq_accepted", DATA_W'(ok), 1);
  endtask

  task automatic pipe_write(input int idx, input logic [DATA_W-1:0] d);
    pipe_val_s1 = 1'b1;
    pipe_rw_s1  = 1'b1;
    wr_idx      = IDX_W'(idx);
    wr_data     = d;
    tick();
    pipe_val_s1 = 1'b0;
    pipe_rw_s1  = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      tick();
      n++;
    end
    check(name, DATA_W'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; evq_val = 1'b0; evq_addr = '0; evq_data = '0;
    pipe_val_s1 = 1'b0; pipe_rw_s1 = 1'b0; wb_rdy = 1'b1; wr_idx = '0; wr_data = '0;
`ifdef VC_FLUSH_EN
    flush_req = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_evq_rdy", DATA_W'(evq_rdy), 0);
    check("reset_se_val", DATA_W'(vc_se_val_s3), 0);
    check("reset_wb_val", DATA_W'(wb_val), 0);
    check("reset_rd_val", DATA_W'(ctrl_vc_val_s1), 0);
    check("reset_busy", DATA_W'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: three clean evictions, each store-evicted the cycle after acceptance.
    for (int i = 0; i < 3; i++) begin
      expect_ev(EV_SE, la(i), ld(i));
      push_ev(la(i), ld(i));
      @(negedge clk);
      check("se_latency", DATA_W'(vc_se_val_s3), 1);
      tick();
    end
    // Fill the rest of the VC so ptr wraps back to 0.
    for (int i = 3; i < NUM_ENTRIES; i++) begin
      expect_ev(EV_SE, la(i), ld(i));
      push_ev(la(i), ld(i));
    end
    wait_drain("drain_fill");

    // 2: dirty victim at idx 0 is read, written back, then replaced by B.
    pipe_write(0, vd(0));
    expect_ev(EV_RD, la(0), '0);
    expect_ev(EV_WB, la(0), vd(0));
    expect_ev(EV_SE, la(16), ld(16));
    push_ev(la(16), ld(16));
    wait_drain("drain_dirty_evict");

    // 3: writeback back-pressured for 5 cycles.
    pipe_write(1, vd(1));
    wb_rdy = 1'b0;
    expect_ev(EV_RD, la(1), '0);
    expect_ev(EV_WB, la(1), vd(1));
    expect_ev(EV_SE, la(17), ld(17));
    push_ev(la(17), ld(17));
    n = 0;
    while (!wb_val && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wb_val_seen", DATA_W'(wb_val), 1);
    repeat (5) tick();
    wb_rdy = 1'b1;
    wait_drain("drain_wb_stall");

    // 4: pipe owns S1 for 4 cycles; controller read waits for the first free cycle.
    pipe_write(2, vd(2));
    expect_ev(EV_RD, la(2), '0);
    expect_ev(EV_WB, la(2), vd(2));
    expect_ev(EV_SE, la(18), ld(18));
    pipe_val_s1 = 1'b1;
    pipe_rw_s1  = 1'b0;
    push_ev(la(18), ld(18));
    repeat (3) tick();
    pipe_val_s1 = 1'b0;
    @(negedge clk);
    check("rd_first_idle_cycle", DATA_W'(ctrl_vc_val_s1), 1);
    tick();
    wait_drain("drain_pipe_busy");

    // 5: three back-to-back pushes while the head is stuck in writeback.
    pipe_write(3, vd(3));
    wb_rdy = 1'b0;
    expect_ev(EV_RD, la(3), '0);
    expect_ev(EV_WB, la(3), vd(3));
    expect_ev(EV_SE, la(19), ld(19));
    expect_ev(EV_SE, la(20), ld(20));
    expect_ev(EV_SE, la(21), ld(21));
    push_ev(la(19), ld(19));
    push_ev(la(20), ld(20));
    evq_val  = 1'b1;
    evq_addr = la(21);
    evq_data = ld(21);
    @(negedge clk);
    check("evq_rdy_full", DATA_W'(evq_rdy), 0);
    tick();
    fork
      push_ev(la(21), ld(21));
      begin
        repeat (8) tick();
        wb_rdy = 1'b1;
      end
    join
    wait_drain("drain_fifo_full");

`ifdef VC_FLUSH_EN
    // 6: flush writes back idx 3 (now la(19)) then idx 9 (la(9)), no store-evicts.
    begin
      int pulses;
      pipe_write(3, vd(30));
      pipe_write(9, vd(90));
      expect_ev(EV_RD, la(19), '0);
      expect_ev(EV_WB, la(19), vd(30));
      expect_ev(EV_RD, la(9), '0);
      expect_ev(EV_WB, la(9), vd(90));
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tick();
      @(negedge clk);
      check("evq_rdy_flushing", DATA_W'(evq_rdy), 0);
      pulses = 0;
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        if (flush_done) pulses++;
      end
      check("flush_done_pulses", DATA_W'(pulses), 1);
      check("flush_events_left", DATA_W'(exp_q.size()), 0);
      // Second flush must find every entry clean.
      tick();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      pulses = 0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (flush_done) pulses++;
      end
      check("flush2_done_pulses", DATA_W'(pulses), 1);
      tick();
    end
`endif

    wait_drain("drain_final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
